// File: rtl/prog_step_counter_pkg.sv
// Shared constants for the front-panel step counter.
//   DIR_UP / DIR_DOWN     : encoding of the dir input
//   MODE_WRAP / MODE_SAT  : encoding of the sat_mode input
//   DEF_*                 : default width and divider settings (50 MHz clock)
package prog_step_counter_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_DIV_FAST = 500000;    // 100 Hz at 50 MHz
  localparam int unsigned DEF_DIV_SLOW = 50000000;  // 1 Hz at 50 MHz
  localparam int unsigned DEF_DIV_W    = 26;

endpackage

// File: rtl/prog_step_counter_if.sv
// Control/status bundle of the step counter.
//   master : drives en, speed, load, load_value, step, dir, sat_mode, capture, clr_flags
//   slave  : drives count, monitor, tick, ovf, ovf_sticky
interface prog_step_counter_if #(
  parameter int unsigned WIDTH = prog_step_counter_pkg::DEF_WIDTH
);

  logic             en;
  logic             speed;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] step;
  logic             dir;
  logic             sat_mode;
  logic             capture;
  logic             clr_flags;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] monitor;
  logic             tick;
  logic             ovf;
  logic             ovf_sticky;

  modport master (
    output en, speed, load, load_value, step, dir, sat_mode, capture, clr_flags,
    input  count, monitor, tick, ovf, ovf_sticky
  );

  modport slave (
    input  en, speed, load, load_value, step, dir, sat_mode, capture, clr_flags,
    output count, monitor, tick, ovf, ovf_sticky
  );

endinterface

// File: rtl/prog_step_counter_tick_divider.sv
// Clock-enable divider: one-cycle tick every DIV_A (i_sel=1) or DIV_B (i_sel=0)
// enabled cycles.
//   clk, rst   : clock, async active-high reset
//   i_en       : 1 = divider advances, 0 = divider holds
//   i_sel      : rate select (1 = DIV_A, 0 = DIV_B)
//   i_restart  : forces the divider back to 0 and suppresses the tick this cycle
//   o_tick_c   : combinational tick, high on the last cycle of each period
module prog_step_counter_tick_divider
  import prog_step_counter_pkg::*;
#(
  parameter int unsigned DIV_A = DEF_DIV_FAST,
  parameter int unsigned DIV_B = DEF_DIV_SLOW,
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_sel,
  input  logic i_restart,
  output logic o_tick_c
);

  localparam logic [DIV_W-1:0] LIM_A = DIV_W'(DIV_A - 1);
  localparam logic [DIV_W-1:0] LIM_B = DIV_W'(DIV_B - 1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_lim;
  logic             w_last;

  // End-of-period detect; >= keeps the counter bounded if the limit ever shrinks
  always_comb begin
    w_lim    = i_sel ? LIM_A : LIM_B;
    w_last   = (r_cnt >= w_lim);
    o_tick_c = i_en & ~i_restart & w_last;
  end

  // Period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/prog_step_counter.sv
// Programmable step counter for the front-panel counter/display path.
// Advances by 'step' on each divider tick, up or down, wrapping or saturating;
// supports synchronous load, a monitor snapshot and a sticky overflow flag.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of prog_step_counter_if (controls in, count/flags out)
module prog_step_counter
  import prog_step_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DIV_FAST = DEF_DIV_FAST,
  parameter int unsigned DIV_SLOW = DEF_DIV_SLOW,
  parameter int unsigned DIV_W    = DEF_DIV_W
) (
  input  logic                  clk,
  input  logic                  rst,
  prog_step_counter_if.slave    bus
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_monitor;
  logic             r_tick;
  logic             r_ovf;
  logic             r_sticky;
  logic             r_speed_q;
  logic             r_speed_vld;

  logic             w_speed_chg;
  logic             w_restart;
  logic             w_tick_int;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_carry;
  logic             w_borrow;
  logic [WIDTH-1:0] w_next_count;
  logic             w_ovf_evt;

  // A rate change only counts once a speed sample has been taken since reset
  always_comb begin
    w_speed_chg = r_speed_vld & (bus.speed != r_speed_q);
    w_restart   = bus.load | w_speed_chg;
  end

  prog_step_counter_tick_divider #(
    .DIV_A (DIV_FAST),
    .DIV_B (DIV_SLOW),
    .DIV_W (DIV_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_en      (bus.en),
    .i_sel     (bus.speed),
    .i_restart (w_restart),
    .o_tick_c  (w_tick_int)
  );

  // Step arithmetic: candidate next count and overflow event for a tick
  always_comb begin
    w_next_count = r_count;
    w_ovf_evt    = 1'b0;
    w_sum        = {1'b0, r_count} + {1'b0, bus.step};
    w_diff       = r_count - bus.step;
    w_carry      = w_sum[WIDTH];
    w_borrow     = (bus.step > r_count);
    if (bus.dir == DIR_UP) begin
      if (w_carry) begin
        w_ovf_evt    = 1'b1;
        w_next_count = (bus.sat_mode == MODE_SAT) ? '1 : w_sum[WIDTH-1:0];
      end else begin
        w_next_count = w_sum[WIDTH-1:0];
      end
    end else begin
      if (w_borrow) begin
        w_ovf_evt    = 1'b1;
        w_next_count = (bus.sat_mode == MODE_SAT) ? '0 : w_diff;
      end else begin
        w_next_count = w_diff;
      end
    end
  end

  // Count, monitor and flag registers; load overrides a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_monitor   <= '0;
      r_tick      <= 1'b0;
      r_ovf       <= 1'b0;
      r_sticky    <= 1'b0;
      r_speed_q   <= 1'b0;
      r_speed_vld <= 1'b0;
    end else begin
      r_speed_q   <= bus.speed;
      r_speed_vld <= 1'b1;
      r_tick      <= 1'b0;
      r_ovf       <= 1'b0;
      if (bus.capture) begin
        r_monitor <= r_count;
      end
      if (bus.load) begin
        r_count  <= bus.load_value;
        r_sticky <= 1'b0;
      end else begin
        if (w_tick_int) begin
          r_count <= w_next_count;
          r_tick  <= 1'b1;
          r_ovf   <= w_ovf_evt;
        end
        // A new overflow wins over a simultaneous clear
        if (w_tick_int && w_ovf_evt) begin
          r_sticky <= 1'b1;
        end else if (bus.clr_flags) begin
          r_sticky <= 1'b0;
        end
      end
    end
  end

  assign bus.count      = r_count;
  assign bus.monitor    = r_monitor;
  assign bus.tick       = r_tick;
  assign bus.ovf        = r_ovf;
  assign bus.ovf_sticky = r_sticky;

endmodule

// File: tb/tb_prog_step_counter.sv
// Bench for prog_step_counter: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the counter.
module tb_prog_step_counter;

  localparam int unsigned W     = 8;
  localparam int          DFAST = 4;
  localparam int          DSLOW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_step_counter_if #(.WIDTH(W)) bus ();

  prog_step_counter #(
    .WIDTH    (W),
    .DIV_FAST (DFAST),
    .DIV_SLOW (DSLOW),
    .DIV_W    (26)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  // Behavioural model state
  int m_phase;   // enabled cycles since the last divider restart
  bit m_vld;
  bit m_prev_speed;
  int m_count;
  int m_mon;
  bit m_tick;
  bit m_ovf;
  bit m_sticky;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, expected %0d at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_vld        = 1'b0;
    m_prev_speed = 1'b0;
    m_count      = 0;
    m_mon        = 0;
    m_tick       = 1'b0;
    m_ovf        = 1'b0;
    m_sticky     = 1'b0;
  endtask

  // One clock edge of the reference: integer arithmetic on the rules
  task automatic model_edge();
    int div;
    bit restart;
    bit tint;
    int n;
    int old;
    div     = bus.speed ? DFAST : DSLOW;
    restart = bus.load || (m_vld && (bus.speed != m_prev_speed));
    tint    = 1'b0;
    old     = m_count;
    if (restart) begin
      m_phase = 0;
    end else if (bus.en) begin
      m_phase++;
      tint = ((m_phase % div) == 0);
    end
    m_tick = 1'b0;
    m_ovf  = 1'b0;
    if (bus.capture) m_mon = old;
    if (bus.load) begin
      m_count  = int'(bus.load_value);
      m_sticky = 1'b0;
    end else begin
      if (tint) begin
        m_tick = 1'b1;
        if (bus.dir == 1'b0) begin
          n = old + int'(bus.step);
          if (n > 255) begin
            m_ovf = 1'b1;
            n = bus.sat_mode ? 255 : n - 256;
          end
        end else begin
          n = old - int'(bus.step);
          if (n < 0) begin
            m_ovf = 1'b1;
            n = bus.sat_mode ? 0 : n + 256;
          end
        end
        m_count = n;
      end
      if (m_ovf) m_sticky = 1'b1;
      else if (bus.clr_flags) m_sticky = 1'b0;
    end
    m_vld        = 1'b1;
    m_prev_speed = bus.speed;
  endtask

  task automatic drive(input bit en, input bit speed, input bit load, input logic [7:0] lv,
                       input logic [7:0] step, input bit dir, input bit sat,
                       input bit cap, input bit clr);
    bus.en         = en;
    bus.speed      = speed;
    bus.load       = load;
    bus.load_value = lv;
    bus.step       = step;
    bus.dir        = dir;
    bus.sat_mode   = sat;
    bus.capture    = cap;
    bus.clr_flags  = clr;
  endtask

  // Advance one edge, update the model and compare every output
  task automatic step_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("count",   32'(bus.count),      32'(m_count));
    check("monitor", 32'(bus.monitor),    32'(m_mon));
    check("tick",    32'(bus.tick),       32'(m_tick));
    check("ovf",     32'(bus.ovf),        32'(m_ovf));
    check("sticky",  32'(bus.ovf_sticky), 32'(m_sticky));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic check_all_zero();
    check("rst_count",   32'(bus.count),      32'd0);
    check("rst_monitor", 32'(bus.monitor),    32'd0);
    check("rst_tick",    32'(bus.tick),       32'd0);
    check("rst_ovf",     32'(bus.ovf),        32'd0);
    check("rst_sticky",  32'(bus.ovf_sticky), 32'd0);
  endtask

  initial begin
    bit spd;
    rst = 1'b1;
    drive(1, 1, 0, 8'd0, 8'd3, 0, 0, 0, 0);
    model_reset();
    #2;
    phase = "reset";
    check_all_zero();
    @(negedge clk);
    rst = 1'b0;

    // Fast rate, step 3 up, wrap: four ticks in 16 cycles
    phase = "t1";
    run(16);
    check("count_after_4_ticks", 32'(bus.count), 32'd12);

    // Wrap overflow and sticky flag
    phase = "t2";
    drive(1, 1, 1, 8'd250, 8'd10, 0, 0, 0, 0);
    run(1);
    drive(1, 1, 0, 8'd0, 8'd10, 0, 0, 0, 0);
    run(4);
    check("wrap_count", 32'(bus.count), 32'd4);
    check("wrap_ovf", 32'(bus.ovf), 32'd1);
    check("wrap_sticky", 32'(bus.ovf_sticky), 32'd1);
    run(1);
    check("ovf_pulse_end", 32'(bus.ovf), 32'd0);
    check("sticky_held", 32'(bus.ovf_sticky), 32'd1);
    drive(1, 1, 0, 8'd0, 8'd10, 0, 0, 0, 1);
    run(1);
    check("sticky_cleared", 32'(bus.ovf_sticky), 32'd0);

    // Saturate up, repeated overflow at the bound
    phase = "t3";
    drive(1, 1, 1, 8'd250, 8'd10, 0, 1, 0, 0);
    run(1);
    drive(1, 1, 0, 8'd0, 8'd10, 0, 1, 0, 0);
    run(4);
    check("sat_count", 32'(bus.count), 32'd255);
    check("sat_ovf", 32'(bus.ovf), 32'd1);
    run(4);
    check("sat_hold_count", 32'(bus.count), 32'd255);
    check("sat_hold_ovf", 32'(bus.ovf), 32'd1);

    // Down with borrow: wrap then saturate
    phase = "t4";
    drive(1, 1, 1, 8'd5, 8'd7, 1, 0, 0, 0);
    run(1);
    drive(1, 1, 0, 8'd0, 8'd7, 1, 0, 0, 0);
    run(4);
    check("down_wrap_count", 32'(bus.count), 32'd254);
    check("down_wrap_ovf", 32'(bus.ovf), 32'd1);
    drive(1, 1, 1, 8'd5, 8'd7, 1, 1, 0, 0);
    run(1);
    drive(1, 1, 0, 8'd0, 8'd7, 1, 1, 0, 0);
    run(4);
    check("down_sat_count", 32'(bus.count), 32'd0);
    check("down_sat_ovf", 32'(bus.ovf), 32'd1);

    // Speed change mid-period, then load and capture on a tick cycle
    phase = "t5";
    drive(1, 1, 0, 8'd0, 8'd1, 0, 0, 0, 0);
    run(2);
    drive(1, 0, 0, 8'd0, 8'd1, 0, 0, 0, 0);
    run(1);
    run(9);
    check("no_tick_before_10", 32'(bus.tick), 32'd0);
    run(1);
    check("tick_at_10", 32'(bus.tick), 32'd1);
    run(9);
    drive(1, 0, 1, 8'd33, 8'd1, 0, 0, 1, 0);
    run(1);
    check("load_on_tick_count", 32'(bus.count), 32'd33);
    check("load_on_tick_tick", 32'(bus.tick), 32'd0);
    check("capture_old_count", 32'(bus.monitor), 32'd1);

    // Asynchronous reset mid-run, then en=0 holds the count
    phase = "t6";
    drive(1, 1, 1, 8'd250, 8'd83, 0, 0, 0, 0);
    run(1);
    drive(1, 1, 0, 8'd0, 8'd83, 0, 0, 0, 0);
    run(4);
    check("pre_rst_count", 32'(bus.count), 32'd77);
    check("pre_rst_sticky", 32'(bus.ovf_sticky), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 1, 8'd77, 8'd5, 0, 0, 0, 0);
    run(1);
    drive(0, 1, 0, 8'd0, 8'd5, 0, 0, 0, 0);
    run(12);
    check("en0_hold_count", 32'(bus.count), 32'd77);

    // Random traffic against the model
    phase = "rand";
    spd = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) spd = ~spd;
      drive(($urandom_range(0, 7) != 0), spd, ($urandom_range(0, 15) == 0),
            8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0));
      step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
